// File: rtl/ofifo_if.sv
// Column-psum bus between the mac_row array, ofifo and its reader; o_err exists only under OFIFO_ERR_FLAG_EN.
// master drives psums, write strobes and pops; slave (the FIFO) returns the head row and flags.
interface ofifo_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16
);
  logic [col*psum_bw-1:0] in;
  logic [col-1:0]         wr;
  logic                   rd;
  logic [col*psum_bw-1:0] out;
  logic                   o_full;
  logic                   o_empty;
  logic                   o_valid;
`ifdef OFIFO_ERR_FLAG_EN
  logic                   o_err;

  modport master (output in, wr, rd, input out, o_full, o_empty, o_valid, o_err);
  modport slave  (input in, wr, rd, output out, o_full, o_empty, o_valid, o_err);
`else
  modport master (output in, wr, rd, input out, o_full, o_empty, o_valid);
  modport slave  (input in, wr, rd, output out, o_full, o_empty, o_valid);
`endif
endinterface

// File: rtl/ofifo.sv
// Per-column FWFT psum FIFOs with an aligned row pop; write visible one edge later, full columns drop writes.
// Optional sticky overflow/underflow flag o_err under OFIFO_ERR_FLAG_EN.
module ofifo #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16
) (
  input logic   clk,
  input logic   reset,
  ofifo_if.slave bus
);
  localparam int AW = $clog2(depth);
  localparam int PW = AW + 1;

  logic [psum_bw-1:0] mem_q [col][depth];
  logic [PW-1:0]      wptr_q [col];
  logic [PW-1:0]      wptr_d [col];
  logic [PW-1:0]      rptr_q [col];
  logic [PW-1:0]      rptr_d [col];
  logic [col-1:0]     full_vec;
  logic [col-1:0]     empty_vec;
  logic [col-1:0]     wr_ok;
  logic               valid_all;
  logic               pop;
  logic [col*psum_bw-1:0] out_row;

  // Count is wptr - rptr modulo 2*depth; the extra pointer bit separates full from empty.
  always_comb begin
    for (int i = 0; i < col; i++) begin
      full_vec[i]  = ((wptr_q[i] - rptr_q[i]) == PW'(depth));
      empty_vec[i] = (wptr_q[i] == rptr_q[i]);
    end
  end

  assign valid_all = ~|empty_vec;
  assign pop       = bus.rd & valid_all;
  assign wr_ok     = bus.wr & ~full_vec;

  always_comb begin
    for (int i = 0; i < col; i++) begin
      wptr_d[i] = wr_ok[i] ? wptr_q[i] + PW'(1) : wptr_q[i];
      rptr_d[i] = pop      ? rptr_q[i] + PW'(1) : rptr_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < col; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage deliberately has no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < col; i++) begin
      if (wr_ok[i]) mem_q[i][wptr_q[i][AW-1:0]] <= bus.in[i*psum_bw +: psum_bw];
    end
  end

  always_comb begin
    out_row = '0;
    if (valid_all) begin
      for (int i = 0; i < col; i++) begin
        out_row[i*psum_bw +: psum_bw] = mem_q[i][rptr_q[i][AW-1:0]];
      end
    end
  end

  assign bus.out     = out_row;
  assign bus.o_full  = |full_vec;
  assign bus.o_empty = &empty_vec;
  assign bus.o_valid = valid_all;

`ifdef OFIFO_ERR_FLAG_EN
  logic err_q;
  logic err_d;

  assign err_d = err_q | (|(bus.wr & full_vec)) | (bus.rd & ~valid_all);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign bus.o_err = err_q;
`endif
endmodule

// File: tb/tb_ofifo.sv
// Directed bench for ofifo with a row scoreboard: rows pushed when written, popped and compared when read.
module tb_ofifo;
  localparam int COL = 8;
  localparam int PB  = 16;
  localparam int DEP = 16;
  localparam int RW  = COL * PB;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [RW-1:0] sb [$];

  ofifo_if #(.col(COL), .psum_bw(PB)) bus ();

  ofifo #(.col(COL), .psum_bw(PB), .depth(DEP)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] rep(input logic [PB-1:0] v);
    return {COL{v}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic v, input logic e, input logic f);
    chk({tag, "_valid"}, RW'(bus.o_valid), RW'(v));
    chk({tag, "_empty"}, RW'(bus.o_empty), RW'(e));
    chk({tag, "_full"},  RW'(bus.o_full),  RW'(f));
  endtask

  task automatic chk_err(input string tag, input logic exp);
`ifdef OFIFO_ERR_FLAG_EN
    chk({tag, "_err"}, RW'(bus.o_err), RW'(exp));
`else
    if (exp === 1'bx) $display("unreachable %s", tag);
`endif
  endtask

  task automatic write_row(input logic [RW-1:0] row);
    bus.in = row;
    bus.wr = '1;
    sb.push_back(row);
    step();
    bus.wr = '0;
  endtask

  // Compare head against scoreboard, then pop on the next edge.
  task automatic read_row(input string tag);
    logic [RW-1:0] exp;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=scoreboard_empty expected=row", tag);
    end else begin
      exp = sb.pop_front();
      chk(tag, bus.out, exp);
    end
    bus.rd = 1'b1;
    step();
    bus.rd = 1'b0;
  endtask

  initial begin
    logic [RW-1:0] row;
    reset  = 1'b1;
    bus.in = '0;
    bus.wr = '0;
    bus.rd = 1'b0;
    #1;
    chk_flags("reset0", 1'b0, 1'b1, 1'b0);
    chk("reset0_out", bus.out, '0);
    chk_err("reset0", 1'b0);
    #2 reset = 1'b0;
    step();

    // Single full-width row of -20s.
    write_row(rep(16'hFFEC));
    chk_flags("row1", 1'b1, 1'b0, 1'b0);
    read_row("row1_out");
    chk_flags("row1_pop", 1'b0, 1'b1, 1'b0);

    // Skewed column arrival.
    row = '0;
    for (int i = 0; i < COL; i++) row[i*PB +: PB] = PB'(i);
    sb.push_back(row);
    for (int i = 0; i < COL; i++) begin
      bus.in = '0;
      bus.in[i*PB +: PB] = PB'(i);
      bus.wr = COL'(1) << i;
      step();
      bus.wr = '0;
      if (i < COL - 1) chk($sformatf("skew_valid%0d", i), RW'(bus.o_valid), RW'(0));
    end
    chk("skew_valid_final", RW'(bus.o_valid), RW'(1));
    read_row("skew_out");
    chk_flags("skew_pop", 1'b0, 1'b1, 1'b0);

    // Fill to depth, overflow is dropped.
    for (int k = 0; k < DEP; k++) write_row(rep(PB'(k)));
    chk_flags("fill", 1'b1, 1'b0, 1'b1);
    chk_err("fill", 1'b0);
    bus.in = rep(16'hDEAD);
    bus.wr = '1;
    step();
    bus.wr = '0;
    chk_flags("ovf", 1'b1, 1'b0, 1'b1);
    chk_err("ovf", 1'b1);
    for (int k = 0; k < DEP; k++) read_row($sformatf("drain%0d", k));
    chk_flags("drained", 1'b0, 1'b1, 1'b0);
    chk_err("drained", 1'b1);

    // Full columns with simultaneous read and write: read wins, write dropped.
    for (int k = 0; k < DEP; k++) write_row(rep(PB'(16'h100 + k)));
    row = sb.pop_front();
    chk("rdwr_head", bus.out, row);
    bus.in = rep(16'hDEAD);
    bus.wr = '1;
    bus.rd = 1'b1;
    step();
    bus.wr = '0;
    bus.rd = 1'b0;
    chk_flags("rdwr", 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < DEP - 1; k++) read_row($sformatf("rdwr_drain%0d", k));
    chk_flags("rdwr_drained", 1'b0, 1'b1, 1'b0);

    // Wrap: one row in flight, 40 same-edge write/read pairs.
    write_row(rep(16'h2000));
    for (int k = 1; k <= 40; k++) begin
      row = rep(PB'(16'h2000 + k));
      bus.in = row;
      bus.wr = '1;
      sb.push_back(row);
      read_row($sformatf("wrap%0d", k));
      bus.wr = '0;
      chk($sformatf("wrap_valid%0d", k), RW'(bus.o_valid), RW'(1));
    end
    read_row("wrap_last");
    chk_flags("wrap_done", 1'b0, 1'b1, 1'b0);

    // Mid-operation reset discards buffered rows.
    for (int k = 0; k < 5; k++) write_row(rep(PB'(16'h3000 + k)));
    #2 reset = 1'b1;
    #1;
    chk_flags("midrst", 1'b0, 1'b1, 1'b0);
    chk("midrst_out", bus.out, '0);
    chk_err("midrst", 1'b0);
    sb.delete();
    #1 reset = 1'b0;
    step();
    write_row(rep(16'h4242));
    chk_flags("fresh", 1'b1, 1'b0, 1'b0);
    read_row("fresh_out");
    chk_flags("fresh_pop", 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
